// File: rtl/breakout_pkg.sv
// Shared definitions for the breakout game blocks: FSM state encodings
// and the scoring constants used by the game sequencer.
package breakout_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_SERVE = 3'd1,
      ST_PLAY  = 3'd2,
      ST_LOST  = 3'd3,
      ST_OVER  = 3'd4,
      ST_WIN   = 3'd5
   } state_t;

   localparam int         SCORE_PER_BLOCK = 5;
   localparam logic [8:0] SCORE_MAX       = 9'd511;

   // Add a raw increment to the score, clamping at SCORE_MAX.
   function automatic logic [8:0] scoreSatAdd(input logic [8:0] score,
                                              input logic [10:0] incr);
      logic [11:0] sum;
      sum = {3'b000, score} + {1'b0, incr};
      if (sum > {3'b000, SCORE_MAX}) begin
         return SCORE_MAX;
      end
      return sum[8:0];
   endfunction

endpackage

// File: rtl/popcount17.sv
// Combinational population count of the per-block hit vector.
module popcount17 #(
   parameter int W = 17
) (
   input  logic [W-1:0] i_bits,
   output logic [4:0]   o_count
);

   // Sum the set bits of the input vector.
   always_comb begin
      o_count = 5'd0;
      for (int i = 0; i < W; i++) begin
         o_count = o_count + {4'b0000, i_bits[i]};
      end
   end

endmodule

// File: rtl/game_sequencer.sv
// Breakout game flow controller: start, serve delay, play, life loss,
// game over and win, plus block-hit scoring with saturation.
module game_sequencer
   import breakout_pkg::*;
#(
   parameter int LIVES        = 3,
   parameter int SERVE_FRAMES = 60,
   parameter int NUM_BLOCKS   = 17
) (
   input  logic                  i_clk,
   input  logic                  i_rst_n,
   input  logic                  i_ani_stb,
   input  logic                  i_start,
   input  logic                  i_endgame,
   input  logic                  i_win,
   input  logic [NUM_BLOCKS-1:0] i_col_detected,
   output logic                  o_mode,
   output logic                  o_animate,
   output logic [2:0]            o_state,
   output logic [1:0]            o_lives,
   output logic [8:0]            o_score,
   output logic                  o_game_over,
   output logic                  o_win
);

   localparam logic [1:0] LIVES_INIT = 2'(LIVES);
   localparam logic [7:0] SERVE_LAST = 8'(SERVE_FRAMES - 1);

   state_t                state_q, state_d;
   logic [1:0]            lives_q, lives_d;
   logic [8:0]            score_q, score_d;
   logic [7:0]            serveCnt_q, serveCnt_d;
   logic                  endgamePrev_q;
   logic [NUM_BLOCKS-1:0] colPrev_q;
   logic                  mode_q, animate_q, gameOver_q, win_q;

   logic [NUM_BLOCKS-1:0] newHits;
   logic [4:0]            hitCount;
   logic                  ballLost;
   logic [10:0]           hitPoints;

   // Blocks that went from clear to hit this cycle; falling edges never score.
   assign newHits   = i_col_detected & ~colPrev_q;
   assign ballLost  = i_endgame & ~endgamePrev_q;
   assign hitPoints = 11'(hitCount) * 11'(SCORE_PER_BLOCK);

   popcount17 #(
      .W(NUM_BLOCKS)
   ) u_popcount (
      .i_bits (newHits),
      .o_count(hitCount)
   );

   // Next-state, lives, score and serve-counter logic.
   always_comb begin
      state_d    = state_q;
      lives_d    = lives_q;
      score_d    = score_q;
      serveCnt_d = serveCnt_q;
      case (state_q)
         ST_IDLE, ST_OVER, ST_WIN: begin
            if (i_start) begin
               state_d    = ST_SERVE;
               lives_d    = LIVES_INIT;
               score_d    = 9'd0;
               serveCnt_d = 8'd0;
            end
         end
         ST_SERVE: begin
            if (i_ani_stb) begin
               if (serveCnt_q == SERVE_LAST) begin
                  state_d    = ST_PLAY;
                  serveCnt_d = 8'd0;
               end else begin
                  serveCnt_d = serveCnt_q + 8'd1;
               end
            end
         end
         ST_PLAY: begin
            score_d = scoreSatAdd(score_q, hitPoints);
            if (i_win) begin
               state_d = ST_WIN;
            end else if (ballLost) begin
               state_d = ST_LOST;
            end
         end
         ST_LOST: begin
            serveCnt_d = 8'd0;
            if (lives_q <= 2'd1) begin
               lives_d = 2'd0;
               state_d = ST_OVER;
            end else begin
               lives_d = lives_q - 2'd1;
               state_d = ST_SERVE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State, counters, edge-detect history and decoded outputs, all registered.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q       <= ST_IDLE;
         lives_q       <= 2'd0;
         score_q       <= 9'd0;
         serveCnt_q    <= 8'd0;
         endgamePrev_q <= 1'b0;
         colPrev_q     <= '0;
         mode_q        <= 1'b0;
         animate_q     <= 1'b0;
         gameOver_q    <= 1'b0;
         win_q         <= 1'b0;
      end else begin
         state_q       <= state_d;
         lives_q       <= lives_d;
         score_q       <= score_d;
         serveCnt_q    <= serveCnt_d;
         endgamePrev_q <= i_endgame;
         colPrev_q     <= i_col_detected;
         mode_q        <= (state_d == ST_SERVE) || (state_d == ST_PLAY) ||
                          (state_d == ST_LOST);
         animate_q     <= (state_d == ST_PLAY);
         gameOver_q    <= (state_d == ST_OVER);
         win_q         <= (state_d == ST_WIN);
      end
   end

   assign o_state     = state_q;
   assign o_lives     = lives_q;
   assign o_score     = score_q;
   assign o_mode      = mode_q;
   assign o_animate   = animate_q;
   assign o_game_over = gameOver_q;
   assign o_win       = win_q;

endmodule

// File: tb/tb_game_sequencer.sv
// Directed self-checking bench for game_sequencer with default parameters.
module tb_game_sequencer;

   logic        i_clk;
   logic        i_rst_n;
   logic        i_ani_stb;
   logic        i_start;
   logic        i_endgame;
   logic        i_win;
   logic [16:0] i_col_detected;
   logic        o_mode;
   logic        o_animate;
   logic [2:0]  o_state;
   logic [1:0]  o_lives;
   logic [8:0]  o_score;
   logic        o_game_over;
   logic        o_win;

   int total = 0;
   int bad   = 0;

   game_sequencer dut (
      .i_clk         (i_clk),
      .i_rst_n       (i_rst_n),
      .i_ani_stb     (i_ani_stb),
      .i_start       (i_start),
      .i_endgame     (i_endgame),
      .i_win         (i_win),
      .i_col_detected(i_col_detected),
      .o_mode        (o_mode),
      .o_animate     (o_animate),
      .o_state       (o_state),
      .o_lives       (o_lives),
      .o_score       (o_score),
      .o_game_over   (o_game_over),
      .o_win         (o_win)
   );

   // Free-running 10 ns clock.
   initial begin
      i_clk = 1'b0;
      forever #5 i_clk = ~i_clk;
   end

   // Advance one clock and land 1 ns after the rising edge.
   task automatic cycle();
      @(posedge i_clk);
      #1;
   endtask

   // Pulse start for one cycle.
   task automatic pulseStart();
      i_start = 1'b1;
      cycle();
      i_start = 1'b0;
   endtask

   // Deliver n frame strobes, each followed by an idle cycle.
   task automatic strobes(input int n);
      for (int k = 0; k < n; k++) begin
         i_ani_stb = 1'b1;
         cycle();
         i_ani_stb = 1'b0;
         cycle();
      end
   endtask

   task automatic test_reset();
      i_rst_n = 1'b0;
      #3;
      total++;
      if ({o_state, o_lives, o_score, o_mode, o_animate, o_game_over, o_win} !== 17'd0) begin
         bad++;
         $display("[TB] FAIL reset_outputs: got state=%0d lives=%0d score=%0d mode=%b anim=%b over=%b win=%b expected all 0",
                  o_state, o_lives, o_score, o_mode, o_animate, o_game_over, o_win);
      end
      cycle();
      i_rst_n = 1'b1;
      cycle();
      cycle();
      total++;
      if (o_state !== 3'd0) begin
         bad++;
         $display("[TB] FAIL idle_hold: got state=%0d expected 0", o_state);
      end
   endtask

   task automatic test_start_serve();
      pulseStart();
      total++;
      if (o_state !== 3'd1 || o_mode !== 1'b1 || o_animate !== 1'b0 || o_lives !== 2'd3 || o_score !== 9'd0) begin
         bad++;
         $display("[TB] FAIL serve_entry: got state=%0d mode=%b anim=%b lives=%0d score=%0d expected 1 1 0 3 0",
                  o_state, o_mode, o_animate, o_lives, o_score);
      end
      strobes(59);
      total++;
      if (o_state !== 3'd1 || o_animate !== 1'b0) begin
         bad++;
         $display("[TB] FAIL serve_59: got state=%0d anim=%b expected 1 0", o_state, o_animate);
      end
      i_ani_stb = 1'b1;
      cycle();
      i_ani_stb = 1'b0;
      total++;
      if (o_state !== 3'd2 || o_animate !== 1'b1 || o_mode !== 1'b1) begin
         bad++;
         $display("[TB] FAIL play_on_60: got state=%0d anim=%b mode=%b expected 2 1 1", o_state, o_animate, o_mode);
      end
   endtask

   task automatic test_life_loss();
      logic [1:0] expLives [3];
      expLives[0] = 2'd2;
      expLives[1] = 2'd1;
      expLives[2] = 2'd0;
      for (int n = 0; n < 3; n++) begin
         cycle();
         i_endgame = 1'b1;
         cycle();
         total++;
         if (o_state !== 3'd3 || o_mode !== 1'b1) begin
            bad++;
            $display("[TB] FAIL lost_%0d: got state=%0d mode=%b expected 3 1", n, o_state, o_mode);
         end
         cycle();
         i_endgame = 1'b0;
         total++;
         if (o_lives !== expLives[n]) begin
            bad++;
            $display("[TB] FAIL lives_%0d: got %0d expected %0d", n, o_lives, expLives[n]);
         end
         if (n < 2) begin
            total++;
            if (o_state !== 3'd1) begin
               bad++;
               $display("[TB] FAIL reserve_%0d: got state=%0d expected 1", n, o_state);
            end
            strobes(60);
         end else begin
            total++;
            if (o_state !== 3'd4 || o_mode !== 1'b0 || o_game_over !== 1'b1 || o_animate !== 1'b0) begin
               bad++;
               $display("[TB] FAIL game_over: got state=%0d mode=%b over=%b anim=%b expected 4 0 1 0",
                        o_state, o_mode, o_game_over, o_animate);
            end
         end
      end
      cycle();
      cycle();
      total++;
      if (o_lives !== 2'd0 || o_state !== 3'd4) begin
         bad++;
         $display("[TB] FAIL over_hold: got lives=%0d state=%0d expected 0 4", o_lives, o_state);
      end
   endtask

   task automatic test_scoring();
      i_col_detected = 17'h00003;
      cycle();
      total++;
      if (o_score !== 9'd0) begin
         bad++;
         $display("[TB] FAIL no_score_over: got %0d expected 0", o_score);
      end
      i_col_detected = 17'h0;
      cycle();
      pulseStart();
      strobes(60);
      total++;
      if (o_state !== 3'd2) begin
         bad++;
         $display("[TB] FAIL restart_play: got state=%0d expected 2", o_state);
      end
      i_col_detected = 17'h00003;
      cycle();
      total++;
      if (o_score !== 9'd10) begin
         bad++;
         $display("[TB] FAIL score_10: got %0d expected 10", o_score);
      end
      i_col_detected = 17'h00007;
      cycle();
      total++;
      if (o_score !== 9'd15) begin
         bad++;
         $display("[TB] FAIL score_15: got %0d expected 15", o_score);
      end
      cycle();
      i_col_detected = 17'h0;
      cycle();
      cycle();
      total++;
      if (o_score !== 9'd15) begin
         bad++;
         $display("[TB] FAIL score_fall: got %0d expected 15", o_score);
      end
   endtask

   task automatic test_saturation();
      for (int k = 0; k < 5; k++) begin
         i_col_detected = 17'h1FFFF;
         cycle();
         i_col_detected = 17'h0;
         cycle();
      end
      total++;
      if (o_score !== 9'd440) begin
         bad++;
         $display("[TB] FAIL score_440: got %0d expected 440", o_score);
      end
      i_col_detected = 17'h03FFF;
      cycle();
      i_col_detected = 17'h0;
      cycle();
      total++;
      if (o_score !== 9'd510) begin
         bad++;
         $display("[TB] FAIL score_510: got %0d expected 510", o_score);
      end
      i_col_detected = 17'h00001;
      cycle();
      total++;
      if (o_score !== 9'd511) begin
         bad++;
         $display("[TB] FAIL score_sat: got %0d expected 511", o_score);
      end
      i_col_detected = 17'h00003;
      cycle();
      i_col_detected = 17'h0;
      cycle();
      total++;
      if (o_score !== 9'd511) begin
         bad++;
         $display("[TB] FAIL score_sat_hold: got %0d expected 511", o_score);
      end
   endtask

   task automatic test_simultaneous();
      i_win     = 1'b1;
      i_endgame = 1'b1;
      cycle();
      i_win     = 1'b0;
      total++;
      if (o_state !== 3'd5 || o_win !== 1'b1 || o_lives !== 2'd3 || o_mode !== 1'b0 || o_animate !== 1'b0) begin
         bad++;
         $display("[TB] FAIL win_priority: got state=%0d win=%b lives=%0d mode=%b anim=%b expected 5 1 3 0 0",
                  o_state, o_win, o_lives, o_mode, o_animate);
      end
      cycle();
      i_endgame = 1'b0;
      cycle();
      total++;
      if (o_state !== 3'd5 || o_score !== 9'd511 || o_lives !== 2'd3) begin
         bad++;
         $display("[TB] FAIL win_hold: got state=%0d score=%0d lives=%0d expected 5 511 3", o_state, o_score, o_lives);
      end
   endtask

   task automatic test_reset_mid_serve();
      pulseStart();
      total++;
      if (o_state !== 3'd1 || o_score !== 9'd0 || o_win !== 1'b0) begin
         bad++;
         $display("[TB] FAIL win_restart: got state=%0d score=%0d win=%b expected 1 0 0", o_state, o_score, o_win);
      end
      strobes(10);
      #2;
      i_rst_n = 1'b0;
      #1;
      total++;
      if ({o_state, o_lives, o_score, o_mode, o_animate, o_game_over, o_win} !== 17'd0) begin
         bad++;
         $display("[TB] FAIL reset_mid: got state=%0d lives=%0d score=%0d mode=%b expected all 0",
                  o_state, o_lives, o_score, o_mode);
      end
      cycle();
      i_rst_n = 1'b1;
      strobes(60);
      total++;
      if (o_state !== 3'd0 || o_mode !== 1'b0) begin
         bad++;
         $display("[TB] FAIL idle_after_reset: got state=%0d mode=%b expected 0 0", o_state, o_mode);
      end
      pulseStart();
      strobes(60);
      pulseStart();
      cycle();
      total++;
      if (o_state !== 3'd2 || o_lives !== 2'd3 || o_animate !== 1'b1) begin
         bad++;
         $display("[TB] FAIL start_in_play: got state=%0d lives=%0d anim=%b expected 2 3 1", o_state, o_lives, o_animate);
      end
   endtask

   // Run every scenario in order, then report.
   initial begin
      i_rst_n        = 1'b1;
      i_ani_stb      = 1'b0;
      i_start        = 1'b0;
      i_endgame      = 1'b0;
      i_win          = 1'b0;
      i_col_detected = 17'h0;
      #2;
      test_reset();
      test_start_serve();
      test_life_loss();
      test_scoring();
      test_saturation();
      test_simultaneous();
      test_reset_mid_serve();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/game_sequencer.md
GAME_SEQUENCER -- requirements
Module: game_sequencer

Interface
REQ-001 SHALL have parameter LIVES, default 3: lives granted per game (1-3).
REQ-002 SHALL have parameter SERVE_FRAMES, default 60: frames the ball is held before launch (1-255).
REQ-003 SHALL have parameter NUM_BLOCKS, default 17: number of breakable blocks.
REQ-004 SHALL have port i_clk, input, 1: base clock; the only clock.
REQ-005 SHALL have port i_rst_n, input, 1: reset, asynchronous, active-low.
REQ-006 SHALL have port i_ani_stb, input, 1: one-cycle frame strobe.
REQ-007 SHALL have port i_start, input, 1: debounced start button, one-cycle pulse.
REQ-008 SHALL have port i_endgame, input, 1: ball-lost flag from the ball block.
REQ-009 SHALL have port i_win, input, 1: all-blocks-cleared flag from the ball block.
REQ-010 SHALL have port i_col_detected, input, NUM_BLOCKS: per-block hit flags from the ball block.
REQ-011 SHALL have port o_mode, output, 1: ball/block enable; low forces the ball to its start position and clears block flags.
REQ-012 SHALL have port o_animate, output, 1: ball motion enable.
REQ-013 SHALL have port o_state, output, 3: current FSM state encoding.
REQ-014 SHALL have port o_lives, output, 2: remaining lives.
REQ-015 SHALL have port o_score, output, 9: game score.
REQ-016 SHALL have ports o_game_over and o_win, output, 1 each: terminal-state indicators.

Function
REQ-017 SHALL implement states IDLE=0, SERVE=1, PLAY=2, LOST=3, OVER=4, WIN=5.
REQ-018 SHALL decode outputs by state:
- o_mode high in SERVE, PLAY and LOST only.
- o_animate high in PLAY only.
- o_game_over high in OVER only.
- o_win high in WIN only.
REQ-019 SHALL, on i_start in IDLE, OVER or WIN, go to SERVE next cycle, load lives=LIVES, clear score and serve counter.
REQ-020 SHALL ignore i_start in SERVE, PLAY and LOST.
REQ-021 SHALL, in SERVE, count i_ani_stb pulses from 0 and enter PLAY on the strobe where count equals SERVE_FRAMES-1.
REQ-022 SHALL, in PLAY, treat a rising edge of i_endgame (versus its previous-cycle value) as ball lost and enter LOST.
REQ-023 SHALL, in LOST (one cycle), decrement lives:
- go to OVER when lives was 1;
- otherwise go to SERVE with the serve counter cleared.
REQ-024 SHALL, in PLAY, enter WIN when i_win is high.
REQ-025 SHALL give i_win priority over a ball-lost edge in the same cycle (go to WIN; lives unchanged).
REQ-026 SHALL compute new hits as i_col_detected AND NOT (previous-cycle i_col_detected), in PLAY only.
REQ-027 SHALL add 5 × popcount(new hits) to the score each cycle, saturating at 511.
REQ-028 SHALL keep the score across lives and in OVER/WIN, clearing it only on game start (REQ-019) or reset.
REQ-029 SHALL ignore falling edges of i_col_detected (block flags cleared by o_mode low) for scoring.
REQ-030 SHALL never underflow lives; lives SHALL hold 0 in OVER.
REQ-031 SHALL register all outputs; o_state SHALL reflect the state one cycle after the transition condition.

Reset
REQ-032 SHALL, on i_rst_n low (asynchronous), force:
- state IDLE;
- lives 0, score 0, serve counter 0;
- edge-detect registers 0;
- all outputs low.
REQ-033 SHALL, on reset release mid-game, restart in IDLE and require i_start to resume.

Structure
REQ-034 SHALL take state encodings, SCORE_PER_BLOCK=5 and SCORE_MAX=511 from shared package breakout_pkg.
REQ-035 SHALL use one combinational sub-module popcount17 (NUM_BLOCKS-bit in, 5-bit count out).

Verification
REQ-036 SHALL cover start-and-serve timing, default parameters:
- stimulus: i_start pulse, then 60 frame strobes;
- response: SERVE with o_mode=1, o_animate=0, o_lives=3; PLAY on strobe 60, o_animate=1.
REQ-037 SHALL cover the life-loss path:
- stimulus: three separate i_endgame rising edges in PLAY;
- response: lives 3→2→1→0, SERVE after the first two, OVER after the third with o_mode=0, o_game_over=1.
REQ-038 SHALL cover scoring:
- stimulus: i_col_detected 0→0x00003→0x00007 in PLAY;
- response: score 10 then 15; dropping the flags to 0 leaves score 15.
REQ-039 SHALL cover simultaneous events:
- stimulus: i_win and an i_endgame rising edge in the same PLAY cycle;
- response: WIN, o_win=1, lives unchanged.
REQ-040 SHALL cover score saturation:
- stimulus: force score 508, then 1 new hit;
- response: score 511.
REQ-041 SHALL cover reset mid-operation:
- stimulus: i_rst_n low mid-SERVE;
- response: IDLE immediately, all outputs 0; i_start ignored in PLAY.
